alu_cmd_driver: RTL and testbench
=================================

Name: alu_cmd_driver

Overview:
- Sequential front end that issues operations to the combinational `alu` (X, Y, op -> ans) and returns the results.
- Accepts commands {tag, X, Y, op} on a valid/ready port into a small command FIFO.
- Drives registered operands into an internal `alu` instance, captures `ans`, and presents {tag, result} on a valid/ready result port.
- Replaces ad-hoc bench-style stimulus with a hardware requester usable by the core and by system-level sims.

Parameters:
- WORD_WIDTH, `WORD_WIDTH (16), operand/result width
- ALUOP_WIDTH, `ALUOP_WIDTH, opcode width
- TAG_WIDTH, 4, command tag width, returned unchanged with the result
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2
- CNT_WIDTH, 16, completed-operation counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_tag  in  TAG_WIDTH  command tag
- cmd_x  in  WORD_WIDTH  operand X
- cmd_y  in  WORD_WIDTH  operand Y
- cmd_op  in  ALUOP_WIDTH  opcode, passed to alu unmodified
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts result
- res_tag  out  TAG_WIDTH  tag of the returned command
- res_data  out  WORD_WIDTH  alu ans captured for that command
- busy  out  1  FIFO non-empty or FSM not IDLE
- done_cnt  out  CNT_WIDTH  number of results accepted by the consumer

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - Outputs: cmd_ready=0 during rst, 1 on the first cycle after; res_valid=0; res_tag=0; res_data=0; busy=0; done_cnt=0.
  - Internal: FIFO pointers=0; FSM=IDLE; alu operand registers=0.
- Reset mid-operation discards all queued commands and any held result; no partial result is ever presented.
- Command FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full, registered-state based; it has no combinational path from cmd_valid.
  - Pointers are (log2(FIFO_DEPTH)+1) bits; the MSB distinguishes full from empty.
  - Wrap-around is silent.
  - Push and pop in the same cycle are both allowed, including when full (pop frees a slot, but cmd_ready was already 0 that cycle, so no push occurs) and when empty (no pop).
- FSM (IDLE, ISSUE, CAPTURE, HOLD):
  - IDLE: if FIFO non-empty, pop the head, load x_q/y_q/op_q/tag_q, go to ISSUE.
  - ISSUE: alu inputs are driven from x_q/y_q/op_q (one settle cycle), go to CAPTURE.
  - CAPTURE: res_data <= ans, res_tag <= tag_q, res_valid <= 1, go to HOLD.
  - HOLD: when res_valid && res_ready, clear res_valid and increment done_cnt.
    - If FIFO non-empty that same cycle, pop the next head and go directly to ISSUE (back-to-back).
    - Otherwise go to IDLE.
- Latency: a command pushed at cycle N into an empty, idle block gives res_valid at N+3.
- Sustained throughput with res_ready=1 is one result per 3 cycles.
- res_tag/res_data are stable while res_valid=1 and res_ready=0. Backpressure is unbounded and no result is dropped.
- done_cnt wraps modulo 2^CNT_WIDTH.
- Arithmetic is entirely inside `alu`. This block never inspects or modifies op. Width follows `alu` (WORD_WIDTH, no carry-out).
- busy = (FSM != IDLE) || !empty.

Decomposition:
- defines.v (shared): WORD_WIDTH, ALUOP_WIDTH, opcode constants ALUOP_ADD=1, ALUOP_SUB=2 used by benches; new entry ALU_TAG_WIDTH.
- Sub-module `cmd_fifo`: synchronous FIFO parameterised by width and depth, with push/pop/full/empty. It is reused by the result path of later blocks.
- The `alu` instance is the existing module, unchanged.

Test Plan:
- Single command: reset; push {tag=3, X=0x0000, Y=0x0001, op=1} at cycle N -> res_valid at N+3, res_tag=3, res_data=0x0001, done_cnt=1 after accept.
- Back-to-back with res_ready=1: push X=0x0110/Y=0x0001/op=1, then X=0x0110/Y=0x0100/op=1, then op=2 with the same operands -> results 0x0111, 0x0210, 0x0010 in order with tags preserved, spaced 3 cycles apart.
- Full FIFO: hold res_ready=0 and push 6 commands -> cmd_ready drops after FIFO_DEPTH+1 accepted (4 queued plus 1 in flight); result 1 is held stable for 20 cycles; release -> all 5 return in order and done_cnt=5.
- Backpressure: toggle res_ready randomly for 200 commands -> scoreboard matches a reference alu model, no loss or duplication, and no res_* change while stalled.
- Reset mid-operation: assert rst during HOLD with 2 commands queued -> next cycle res_valid=0, busy=0, done_cnt=0; a new command then returns with the normal 3-cycle latency.
- Wrap: issue 2^CNT_WIDTH+2 operations with CNT_WIDTH=4 -> done_cnt reads 2; FIFO pointers wrap without corruption.

Source files
------------

// File: rtl/alu_cmd_driver_pkg.sv
// Shared widths, opcodes and FSM encoding for the ALU command driver.
package alu_cmd_driver_pkg;

  localparam int WORD_WIDTH    = 16;
  localparam int ALUOP_WIDTH   = 3;
  localparam int ALU_TAG_WIDTH = 4;

  localparam int ALUOP_ADD = 1;
  localparam int ALUOP_SUB = 2;
  localparam int ALUOP_AND = 3;
  localparam int ALUOP_OR  = 4;
  localparam int ALUOP_XOR = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_HOLD
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: ans = f(x, y, op), result truncated to the word width.
module alu
  import alu_cmd_driver_pkg::*;
#(
  parameter int W   = WORD_WIDTH,
  parameter int OPW = ALUOP_WIDTH
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic [OPW-1:0] op,
  output logic [W-1:0]   ans
);

  always_comb begin
    ans = '0;
    case (op)
      OPW'(ALUOP_ADD): ans = x + y;
      OPW'(ALUOP_SUB): ans = x - y;
      OPW'(ALUOP_AND): ans = x & y;
      OPW'(ALUOP_OR):  ans = x | y;
      OPW'(ALUOP_XOR): ans = x ^ y;
      default:         ans = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_driver_cmd_fifo.sv
// Synchronous FIFO; pointers carry one extra MSB to tell full from empty.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Queues tagged ALU commands, issues them one at a time to the alu and
// returns {tag, result} on a valid/ready port.
module alu_cmd_driver
  import alu_cmd_driver_pkg::*;
#(
  parameter int WORD_WIDTH  = alu_cmd_driver_pkg::WORD_WIDTH,
  parameter int ALUOP_WIDTH = alu_cmd_driver_pkg::ALUOP_WIDTH,
  parameter int TAG_WIDTH   = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [TAG_WIDTH-1:0]   cmd_tag,
  input  logic [WORD_WIDTH-1:0]  cmd_x,
  input  logic [WORD_WIDTH-1:0]  cmd_y,
  input  logic [ALUOP_WIDTH-1:0] cmd_op,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [TAG_WIDTH-1:0]   res_tag,
  output logic [WORD_WIDTH-1:0]  res_data,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   done_cnt
);

  localparam int CW = TAG_WIDTH + 2 * WORD_WIDTH + ALUOP_WIDTH;

  state_t                 state;
  state_t                 state_n;
  logic [WORD_WIDTH-1:0]  x_q;
  logic [WORD_WIDTH-1:0]  y_q;
  logic [ALUOP_WIDTH-1:0] op_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [WORD_WIDTH-1:0]  ans;
  logic [CW-1:0]          head;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic                   load;
  logic                   cap;
  logic                   acc;

  // Ready depends only on stored state and reset, never on cmd_valid.
  assign cmd_ready = !full && !rst;
  assign busy      = (state != S_IDLE) || !empty;

  cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .pop   (pop),
    .din   ({cmd_tag, cmd_x, cmd_y, cmd_op}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  alu #(
    .W   (WORD_WIDTH),
    .OPW (ALUOP_WIDTH)
  ) u_alu (
    .x   (x_q),
    .y   (y_q),
    .op  (op_q),
    .ans (ans)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    load    = 1'b0;
    cap     = 1'b0;
    acc     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_CAPTURE;
      S_CAPTURE: begin
        cap     = 1'b1;
        state_n = S_HOLD;
      end
      S_HOLD: begin
        if (res_valid && res_ready) begin
          acc = 1'b1;
          // Chain straight into the next command when one is waiting.
          if (!empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_n = S_ISSUE;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_data  <= '0;
      done_cnt  <= '0;
    end else begin
      state <= state_n;
      if (load) {tag_q, x_q, y_q, op_q} <= head;
      if (cap) begin
        res_data  <= ans;
        res_tag   <= tag_q;
        res_valid <= 1'b1;
      end else if (acc) begin
        res_valid <= 1'b0;
      end
      if (acc) done_cnt <= done_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver with a behavioural ALU reference.
module tb_alu_cmd_driver;

  localparam int W   = 16;
  localparam int OPW = 3;
  localparam int TW  = 4;
  localparam int CNW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [TW-1:0]  cmd_tag = '0;
  logic [W-1:0]   cmd_x = '0;
  logic [W-1:0]   cmd_y = '0;
  logic [OPW-1:0] cmd_op = '0;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [TW-1:0]  res_tag;
  logic [W-1:0]   res_data;
  logic           busy;
  logic [CNW-1:0] done_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc = 0;
  int acc_cyc = 0;
  int rr_mode = 1;
  bit started = 1'b0;
  bit held_v = 1'b0;
  logic [TW+W-1:0] held;
  logic [TW+W-1:0] exp_q [$];
  int hs_q [$];

  alu_cmd_driver #(
    .WORD_WIDTH  (W),
    .ALUOP_WIDTH (OPW),
    .TAG_WIDTH   (TW),
    .FIFO_DEPTH  (4),
    .CNT_WIDTH   (CNW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_tag   (cmd_tag),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_op    (cmd_op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_tag   (res_tag),
    .res_data  (res_data),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = 1'b0;
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic logic [W-1:0] ref_alu(logic [W-1:0] x, logic [W-1:0] y,
                                           logic [OPW-1:0] op);
    case (op)
      3'd1:    return x + y;
      3'd2:    return x - y;
      3'd3:    return x & y;
      3'd4:    return x | y;
      3'd5:    return x ^ y;
      default: return '0;
    endcase
  endfunction

  task automatic check(string name, longint act, longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake.
  always @(negedge clk) begin
    if (started && !rst) begin
      if (held_v && res_valid) begin
        vectors++;
        if ({res_tag, res_data} !== held) begin
          miscompares++;
          $display("FAIL stall_hold: got %h expected %h", {res_tag, res_data}, held);
        end
      end
      vectors++;
      if (done_cnt !== CNW'(acc)) begin
        miscompares++;
        $display("FAIL done_cnt: got %0d expected %0d", done_cnt, CNW'(acc));
      end
      if (res_valid && res_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_result: got %h expected none", {res_tag, res_data});
        end else begin
          logic [TW+W-1:0] e;
          e = exp_q.pop_front();
          if ({res_tag, res_data} !== e) begin
            miscompares++;
            $display("FAIL result: got %h expected %h", {res_tag, res_data}, e);
          end
        end
        hs_q.push_back(cyc);
        acc++;
      end
      held_v = res_valid && !res_ready;
      held   = {res_tag, res_data};
    end
  end

  // Called at posedge+1; returns at posedge+1 after accept or timeout.
  task automatic send(input logic [TW-1:0] tag, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [OPW-1:0] op,
                      input int bound, output bit ok);
    cmd_valid = 1'b1;
    cmd_tag = tag;
    cmd_x = x;
    cmd_y = y;
    cmd_op = op;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        exp_q.push_back({tag, ref_alu(x, y, op)});
        acc_cyc = cyc + 1;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    if (!seen) begin
      miscompares++;
      $display("FAIL wait_valid: got timeout expected res_valid");
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      @(negedge clk);
      idle = (exp_q.size() == 0) && !busy;
    end
    if (!idle) begin
      miscompares++;
      $display("FAIL wait_idle: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    acc = 0;
    held_v = 1'b0;
    @(negedge clk);
    check("cmd_ready_in_rst", cmd_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    started = 1'b1;
    @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_tag", res_tag, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;

    // Single command latency
    rr_mode = 0;
    send(4'd3, 16'h0000, 16'h0001, 3'd1, 10, ok);
    check("single_accept", ok, 1);
    wait_valid();
    check("single_latency", cyc, acc_cyc + 3);
    wait_idle();
    check("single_done", done_cnt, 1);

    // Back-to-back with spacing
    hs_q.delete();
    send(4'd5, 16'h0110, 16'h0001, 3'd1, 10, ok);
    send(4'd6, 16'h0110, 16'h0100, 3'd1, 10, ok);
    send(4'd7, 16'h0110, 16'h0100, 3'd2, 10, ok);
    wait_idle();
    check("b2b_count", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      check("b2b_gap1", hs_q[1] - hs_q[0], 3);
      check("b2b_gap2", hs_q[2] - hs_q[1], 3);
    end

    // Full FIFO under backpressure
    rr_mode = 1;
    @(posedge clk);
    #1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      send(4'(8 + i), W'($urandom), W'($urandom), 3'd1, 8, ok);
      if (ok) n++;
    end
    check("full_accepted", n, 5);
    @(negedge clk);
    check("full_cmd_ready", cmd_ready, 0);
    repeat (20) @(negedge clk);
    check("full_pending", exp_q.size(), 5);
    @(posedge clk);
    #1;
    n = acc;
    rr_mode = 0;
    wait_idle();
    check("full_returned", acc - n, 5);

    // Random backpressure
    rr_mode = 2;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(4'($urandom), W'($urandom), W'($urandom), 3'($urandom), 200, ok);
      if (!ok) begin
        miscompares++;
        $display("FAIL rand_accept: got timeout expected accept");
      end
    end
    rr_mode = 0;
    wait_idle();

    // Reset while holding with two queued
    rr_mode = 1;
    @(posedge clk);
    #1;
    send(4'd1, 16'h1234, 16'h0001, 3'd1, 10, ok);
    send(4'd2, 16'h1234, 16'h0002, 3'd1, 10, ok);
    send(4'd3, 16'h1234, 16'h0003, 3'd1, 10, ok);
    wait_valid();
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done_cnt, 0);
    @(posedge clk);
    #1;
    rr_mode = 0;
    send(4'd9, 16'hffff, 16'h0002, 3'd1, 10, ok);
    wait_valid();
    check("post_rst_latency", cyc, acc_cyc + 3);
    wait_idle();

    // Counter wrap
    do_reset();
    for (int i = 0; i < 18; i++) begin
      send(4'(i), W'($urandom), W'($urandom), 3'd2, 50, ok);
    end
    wait_idle();
    check("wrap_done_cnt", done_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
